// File: rtl/mode_switch_seq.sv
// rtl/mode_switch_seq.sv - chip-mode switch sequencer: drain, hold core reset, settle, done.
// Optional DRAIN timeout is compiled in with `define MODE_SWITCH_TIMEOUT_EN.
module mode_switch_seq #(
  parameter int RST_CYCLES     = 16,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode_req_valid,
  input  logic [1:0] mode_req,
  output logic       mode_req_ready,
  output logic       quiesce_req,
  input  logic       quiesce_ack,
  output logic       core_rst_o,
  output logic [1:0] chip_mode_o,
  output logic       busy,
  output logic       switch_done,
  output logic       drain_timeout
);

  localparam int MAX_AB = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_ALL = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
`ifdef MODE_SWITCH_TIMEOUT_EN
  localparam logic [CW-1:0] DRAIN_LOAD  = CW'(TIMEOUT_CYCLES - 1);
`else
  localparam logic [CW-1:0] DRAIN_LOAD  = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_RESET  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    target_q, target_d;
  logic [1:0]    chip_mode_q, chip_mode_d;
  logic          mode_req_ready_q, mode_req_ready_d;
  logic          busy_q, busy_d;
  logic          quiesce_req_q, quiesce_req_d;
  logic          core_rst_q, core_rst_d;
  logic          switch_done_q, switch_done_d;
  logic          timeout_hit;

  // State register; every output is a flop so no input reaches an output combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      target_q         <= 2'b00;
      chip_mode_q      <= 2'b00;
      mode_req_ready_q <= 1'b1;
      busy_q           <= 1'b0;
      quiesce_req_q    <= 1'b0;
      core_rst_q       <= 1'b0;
      switch_done_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      target_q         <= target_d;
      chip_mode_q      <= chip_mode_d;
      mode_req_ready_q <= mode_req_ready_d;
      busy_q           <= busy_d;
      quiesce_req_q    <= quiesce_req_d;
      core_rst_q       <= core_rst_d;
      switch_done_q    <= switch_done_d;
    end
  end

  // Next-state logic; the shared counter is reloaded on every timed state entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    chip_mode_d = chip_mode_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mode_req_valid && mode_req_ready_q) begin
          target_d = mode_req;
          if (mode_req == chip_mode_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
            cnt_d   = DRAIN_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (quiesce_ack) begin
          state_d     = S_RESET;
          cnt_d       = RST_LOAD;
          chip_mode_d = target_q;
        end
`ifdef MODE_SWITCH_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d     = S_RESET;
          cnt_d       = RST_LOAD;
          chip_mode_d = target_q;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`endif
      end
      S_RESET: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they line up with the registered state.
  always_comb begin
    mode_req_ready_d = (state_d == S_IDLE);
    busy_d           = (state_d != S_IDLE);
    quiesce_req_d    = (state_d == S_DRAIN) || (state_d == S_RESET) || (state_d == S_SETTLE);
    core_rst_d       = (state_d == S_RESET);
    switch_done_d    = (state_d == S_DONE);
  end

`ifdef MODE_SWITCH_TIMEOUT_EN
  logic drain_timeout_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      drain_timeout_q <= 1'b0;
    end else begin
      drain_timeout_q <= timeout_hit;
    end
  end

  assign drain_timeout = drain_timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_hit;
  assign drain_timeout  = 1'b0;
`endif

  assign mode_req_ready = mode_req_ready_q;
  assign busy           = busy_q;
  assign quiesce_req    = quiesce_req_q;
  assign core_rst_o     = core_rst_q;
  assign chip_mode_o    = chip_mode_q;
  assign switch_done    = switch_done_q;

endmodule

// File: tb/tb_mode_switch_seq.sv
// tb/tb_mode_switch_seq.sv - randomized bench for mode_switch_seq against a timestamp reference model.
module tb_mode_switch_seq;

  localparam int R  = 4;
  localparam int S  = 2;
  localparam int TO = 8;
`ifdef MODE_SWITCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       mode_req_valid;
  logic [1:0] mode_req;
  logic       mode_req_ready;
  logic       quiesce_req;
  logic       quiesce_ack;
  logic       core_rst_o;
  logic [1:0] chip_mode_o;
  logic       busy;
  logic       switch_done;
  logic       drain_timeout;

  mode_switch_seq #(
    .RST_CYCLES    (R),
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mode_req_valid(mode_req_valid),
    .mode_req      (mode_req),
    .mode_req_ready(mode_req_ready),
    .quiesce_req   (quiesce_req),
    .quiesce_ack   (quiesce_ack),
    .core_rst_o    (core_rst_o),
    .chip_mode_o   (chip_mode_o),
    .busy          (busy),
    .switch_done   (switch_done),
    .drain_timeout (drain_timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: one switch is described by the cycle numbers at which each phase starts.
  bit         m_valid = 1'b0;
  bit         m_active = 1'b0;
  bit         m_same = 1'b0;
  bit         m_to_pulse = 1'b0;
  bit         m_accepted = 1'b0;
  logic [1:0] m_mode = 2'b00;
  logic [1:0] m_tgt = 2'b00;
  int         m_t_drain = -1;
  int         m_t_reset = -1;
  int         m_t_settle = -1;
  int         m_t_done = -1;
  int         m_t_idle = -1;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic       e_ready, e_busy, e_q, e_rst, e_done, e_to;
    logic [1:0] e_mode;
    e_ready = 1'b1;
    e_busy  = 1'b0;
    e_q     = 1'b0;
    e_rst   = 1'b0;
    e_done  = 1'b0;
    e_to    = 1'b0;
    e_mode  = m_mode;
    if (m_valid) begin
      if (m_active) begin
        e_ready = 1'b0;
        e_busy  = 1'b1;
        if (m_same) begin
          e_done = (cyc == m_t_done);
        end else if (m_t_reset < 0 || cyc < m_t_reset) begin
          e_q = 1'b1;
        end else begin
          e_mode = m_tgt;
          if (cyc < m_t_settle) begin
            e_q   = 1'b1;
            e_rst = 1'b1;
            e_to  = m_to_pulse && (cyc == m_t_reset);
          end else if (cyc < m_t_done) begin
            e_q = 1'b1;
          end else begin
            e_done = 1'b1;
          end
        end
      end
      check_eq("ready",     {7'd0, mode_req_ready}, {7'd0, e_ready});
      check_eq("busy",      {7'd0, busy},           {7'd0, e_busy});
      check_eq("quiesce",   {7'd0, quiesce_req},    {7'd0, e_q});
      check_eq("core_rst",  {7'd0, core_rst_o},     {7'd0, e_rst});
      check_eq("chip_mode", {6'd0, chip_mode_o},    {6'd0, e_mode});
      check_eq("done",      {7'd0, switch_done},    {7'd0, e_done});
      check_eq("timeout",   {7'd0, drain_timeout},  {7'd0, e_to});
    end
  endtask

  task automatic model_step();
    m_accepted = 1'b0;
    if (reset) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_mode   = 2'b00;
    end else if (m_valid) begin
      if (!m_active) begin
        if (mode_req_valid) begin
          m_accepted = 1'b1;
          m_active   = 1'b1;
          m_tgt      = mode_req;
          m_to_pulse = 1'b0;
          m_t_reset  = -1;
          m_t_idle   = -1;
          if (mode_req == m_mode) begin
            m_same   = 1'b1;
            m_t_done = cyc + 1;
            m_t_idle = cyc + 2;
          end else begin
            m_same    = 1'b0;
            m_t_drain = cyc + 1;
          end
        end
      end else begin
        if (!m_same && m_t_reset < 0) begin
          if (quiesce_ack) begin
            m_t_reset = cyc + 1;
          end else if (TO_EN && (cyc - m_t_drain + 1 == TO)) begin
            m_t_reset  = cyc + 1;
            m_to_pulse = 1'b1;
          end
          if (m_t_reset >= 0) begin
            m_t_settle = m_t_reset + R;
            m_t_done   = m_t_settle + S;
            m_t_idle   = m_t_done + 1;
          end
        end
        if (cyc + 1 == m_t_idle) begin
          m_active = 1'b0;
          m_mode   = m_tgt;
        end
      end
    end
  endtask

  task automatic run_cycle(input logic rst, input logic v, input logic [1:0] r, input logic a);
    reset          = rst;
    mode_req_valid = v;
    mode_req       = r;
    quiesce_ack    = a;
    @(negedge clock);
    check_cycle();
    model_step();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  initial begin
    logic       h_valid;
    logic [1:0] h_req;
    logic       rst;
    h_valid = 1'b0;
    h_req   = 2'b00;
    reset = 1'b1;
    mode_req_valid = 1'b0;
    mode_req = 2'b00;
    quiesce_ack = 1'b0;
    #1;

    // Reset, then idle outputs.
    run_cycle(1'b1, 1'b0, 2'b00, 1'b0);
    run_cycle(1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 2'b00, 1'b0);

    // Request 10, ack arrives on the third DRAIN cycle.
    run_cycle(1'b0, 1'b1, 2'b10, 1'b0);
    run_cycle(1'b0, 1'b0, 2'b00, 1'b0);
    run_cycle(1'b0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b0, 2'b00, 1'b1);

    // Same-mode request after reset.
    run_cycle(1'b1, 1'b0, 2'b00, 1'b0);
    run_cycle(1'b0, 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 2'b00, 1'b0);

    // Switch to 10, then hold a request for 01 while busy.
    run_cycle(1'b0, 1'b1, 2'b10, 1'b1);
    for (int i = 0; i < 25; i++) run_cycle(1'b0, 1'b1, 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 2'b00, 1'b0);

    // Request 11 with ack held low for a long time.
    run_cycle(1'b0, 1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 110; i++) run_cycle(1'b0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b0, 2'b00, 1'b1);

    // Reset on the second RESET cycle.
    run_cycle(1'b1, 1'b0, 2'b00, 1'b0);
    run_cycle(1'b0, 1'b1, 2'b10, 1'b0);
    run_cycle(1'b0, 1'b0, 2'b00, 1'b1);
    run_cycle(1'b0, 1'b0, 2'b00, 1'b1);
    run_cycle(1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 2'b00, 1'b0);

    // Random traffic: requests held until accepted, sparse acks, occasional reset.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (!h_valid && ($urandom_range(0, 3) == 0)) begin
        h_valid = 1'b1;
        h_req   = 2'($urandom_range(0, 3));
      end
      run_cycle(rst, h_valid, h_req, ($urandom_range(0, 9) < 2));
      if (m_accepted) h_valid = 1'b0;
    end
    for (int i = 0; i < 30; i++) run_cycle(1'b0, 1'b0, 2'b00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
